// File: rtl/ifu_pkg.sv
// Shared IFU parameters and types: cache geometry plus the memory-responder
// word geometry and FSM encoding.
package ifu_pkg;

  localparam int TAG_WIDTH      = 8;
  localparam int LINE_WIDTH     = 128;
  localparam int WORD_WIDTH     = 32;
  localparam int WORDS_PER_LINE = LINE_WIDTH / WORD_WIDTH;
  localparam int WIDX_W         = $clog2(WORDS_PER_LINE);

  typedef enum logic [2:0] {
    RSP_IDLE  = 3'd0,
    RSP_WAIT  = 3'd1,
    RSP_READ  = 3'd2,
    RSP_DRAIN = 3'd3,
    RSP_RESP  = 3'd4,
    RSP_COOL  = 3'd5
  } rsp_state_t;

endpackage

// File: rtl/ifu_line_assembler.sv
// Captures SRAM read data one cycle after each issued read and writes it
// into the addressed word slot of the line register.
module ifu_line_assembler #(
  parameter int WORD_WIDTH = 32,
  parameter int N_WORDS    = 4,
  parameter int IDX_W      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          rd_en_i,
  input  logic [IDX_W-1:0]              rd_idx_i,
  input  logic [WORD_WIDTH-1:0]         rd_data_i,
  output logic [N_WORDS*WORD_WIDTH-1:0] line_o
);

  logic                          cap_valid_q, cap_valid_d;
  logic [IDX_W-1:0]              cap_idx_q, cap_idx_d;
  logic [N_WORDS*WORD_WIDTH-1:0] line_q, line_d;

  // Capture pair trails the read by one cycle, matching the SRAM latency.
  always_comb begin
    cap_valid_d = rd_en_i;
    cap_idx_d   = rd_idx_i;
    line_d      = line_q;
    if (cap_valid_q) begin
      line_d[cap_idx_q*WORD_WIDTH +: WORD_WIDTH] = rd_data_i;
    end else begin
      line_d = line_q;
    end
  end

  // Capture and line state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_valid_q <= 1'b0;
      cap_idx_q   <= '0;
      line_q      <= '0;
    end else begin
      cap_valid_q <= cap_valid_d;
      cap_idx_q   <= cap_idx_d;
      line_q      <= line_d;
    end
  end

  assign line_o = line_q;

endmodule

// File: rtl/ifu_mem_rsp.sv
// Memory-side responder for IFU line fills: latches one tag request, reads the
// line word by word from a 1-cycle SRAM, and returns it with a one-cycle pulse.
module ifu_mem_rsp #(
  parameter int WORD_WIDTH = 32,
  parameter int EXTRA_LAT  = 0
) (
  input  logic                                                           Clock,
  input  logic                                                           Rst,
  input  logic [ifu_pkg::TAG_WIDTH-1:0]                                  mem_reqTagIn,
  input  logic                                                           mem_reqTagValidIn,
  output logic [ifu_pkg::TAG_WIDTH-1:0]                                  mem_rspTagOut,
  output logic [ifu_pkg::LINE_WIDTH-1:0]                                 mem_rspInsLineOut,
  output logic                                                           mem_rspInsLineValidOut,
  output logic                                                           sram_rdEnOut,
  output logic [ifu_pkg::TAG_WIDTH+$clog2(ifu_pkg::LINE_WIDTH/WORD_WIDTH)-1:0] sram_rdAddrOut,
  input  logic [WORD_WIDTH-1:0]                                          sram_rdDataIn,
  output logic                                                           busyOut
);

  import ifu_pkg::*;

  localparam int N_WORDS = LINE_WIDTH / WORD_WIDTH;
  localparam int IDX_W   = $clog2(N_WORDS);
  localparam int ADDR_W  = TAG_WIDTH + IDX_W;

  localparam logic [3:0]       LAT_LAST = (EXTRA_LAT > 0) ? 4'(EXTRA_LAT - 1) : 4'd0;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_WORDS - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

  rsp_state_t           state_q, state_d;
  logic [TAG_WIDTH-1:0] cur_tag_q, cur_tag_d;
  logic [IDX_W-1:0]     widx_q, widx_d;
  logic [3:0]           lat_cnt_q, lat_cnt_d;
  logic                 rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]    rd_addr_q, rd_addr_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 busy_q, busy_d;

  // Next-state logic; outputs are derived from the next state so they register cleanly.
  always_comb begin
    state_d   = state_q;
    cur_tag_d = cur_tag_q;
    widx_d    = widx_q;
    lat_cnt_d = lat_cnt_q;
    case (state_q)
      RSP_IDLE: begin
        if (mem_reqTagValidIn) begin
          cur_tag_d = mem_reqTagIn;
          widx_d    = '0;
          lat_cnt_d = 4'd0;
          state_d   = (EXTRA_LAT > 0) ? RSP_WAIT : RSP_READ;
        end else begin
          state_d = RSP_IDLE;
        end
      end
      RSP_WAIT: begin
        lat_cnt_d = lat_cnt_q + 4'd1;
        if (lat_cnt_q == LAT_LAST) begin
          state_d = RSP_READ;
        end else begin
          state_d = RSP_WAIT;
        end
      end
      RSP_READ: begin
        // Index wraps inside its own field; it never carries into the tag.
        widx_d = widx_q + IDX_ONE;
        if (widx_q == IDX_LAST) begin
          state_d = RSP_DRAIN;
        end else begin
          state_d = RSP_READ;
        end
      end
      RSP_DRAIN: state_d = RSP_RESP;
      RSP_RESP:  state_d = RSP_COOL;
      // COOL ignores requests so the cache's post-insert hit update can settle.
      RSP_COOL:  state_d = RSP_IDLE;
      default:   state_d = RSP_IDLE;
    endcase

    rd_en_d     = (state_d == RSP_READ);
    rd_addr_d   = rd_en_d ? {cur_tag_d, widx_d} : '0;
    rsp_valid_d = (state_d == RSP_RESP);
    busy_d      = (state_d != RSP_IDLE);
  end

  // FSM, counters and registered outputs.
  always_ff @(posedge Clock or negedge Rst) begin
    if (!Rst) begin
      state_q     <= RSP_IDLE;
      cur_tag_q   <= '0;
      widx_q      <= '0;
      lat_cnt_q   <= 4'd0;
      rd_en_q     <= 1'b0;
      rd_addr_q   <= '0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_tag_q   <= cur_tag_d;
      widx_q      <= widx_d;
      lat_cnt_q   <= lat_cnt_d;
      rd_en_q     <= rd_en_d;
      rd_addr_q   <= rd_addr_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  ifu_line_assembler #(
    .WORD_WIDTH (WORD_WIDTH),
    .N_WORDS    (N_WORDS),
    .IDX_W      (IDX_W)
  ) u_line_asm (
    .clk       (Clock),
    .rst_n     (Rst),
    .rd_en_i   (rd_en_q),
    .rd_idx_i  (rd_addr_q[IDX_W-1:0]),
    .rd_data_i (sram_rdDataIn),
    .line_o    (mem_rspInsLineOut)
  );

  // The response tag is the latched request tag, updated at acceptance.
  assign mem_rspTagOut          = cur_tag_q;
  assign mem_rspInsLineValidOut = rsp_valid_q;
  assign sram_rdEnOut           = rd_en_q;
  assign sram_rdAddrOut         = rd_addr_q;
  assign busyOut                = busy_q;

endmodule

// File: tb/tb_ifu_mem_rsp.sv
// Randomized bench for ifu_mem_rsp: two instances (no extra latency and
// EXTRA_LAT=3) share stimulus and are checked against a transaction-timing model.
module tb_ifu_mem_rsp;

  localparam int W      = 4;
  localparam int NCYC   = 2500;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  req_tag;
  logic        req_vld;

  logic [1:0]        rd_en_w, vld_w, busy_w;
  logic [1:0][9:0]   addr_w;
  logic [1:0][7:0]   tag_w;
  logic [1:0][127:0] line_w;
  logic [1:0][31:0]  sram_q;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc;

  bit           act [2];
  int           acc [2];
  logic [7:0]   last_tag [2];
  logic [127:0] last_line [2];

  always #5 clk = ~clk;

  ifu_mem_rsp #(.WORD_WIDTH(32), .EXTRA_LAT(0)) dut0 (
    .Clock(clk), .Rst(rst_n), .mem_reqTagIn(req_tag), .mem_reqTagValidIn(req_vld),
    .mem_rspTagOut(tag_w[0]), .mem_rspInsLineOut(line_w[0]), .mem_rspInsLineValidOut(vld_w[0]),
    .sram_rdEnOut(rd_en_w[0]), .sram_rdAddrOut(addr_w[0]), .sram_rdDataIn(sram_q[0]),
    .busyOut(busy_w[0]));

  ifu_mem_rsp #(.WORD_WIDTH(32), .EXTRA_LAT(3)) dut1 (
    .Clock(clk), .Rst(rst_n), .mem_reqTagIn(req_tag), .mem_reqTagValidIn(req_vld),
    .mem_rspTagOut(tag_w[1]), .mem_rspInsLineOut(line_w[1]), .mem_rspInsLineValidOut(vld_w[1]),
    .sram_rdEnOut(rd_en_w[1]), .sram_rdAddrOut(addr_w[1]), .sram_rdDataIn(sram_q[1]),
    .busyOut(busy_w[1]));

  // SRAM models: word address a holds a; junk when not read so timing errors show.
  always @(posedge clk) begin
    sram_q[0] <= rd_en_w[0] ? 32'(addr_w[0]) : $urandom;
    sram_q[1] <= rd_en_w[1] ? 32'(addr_w[1]) : $urandom;
  end

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int lat_of(input int k);
    return (k == 0) ? 0 : 3;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      act[k]       = 1'b0;
      acc[k]       = 0;
      last_tag[k]  = 8'h00;
      last_line[k] = '0;
    end
  endtask

  task automatic check_zero(input int k);
    check_val($sformatf("d%0d rst rd_en", k), rd_en_w[k], 1'b0);
    check_val($sformatf("d%0d rst addr", k),  addr_w[k], 10'h000);
    check_val($sformatf("d%0d rst valid", k), vld_w[k], 1'b0);
    check_val($sformatf("d%0d rst busy", k),  busy_w[k], 1'b0);
    check_val($sformatf("d%0d rst tag", k),   tag_w[k], 8'h00);
    check_val($sformatf("d%0d rst line", k),  line_w[k], 128'h0);
  endtask

  // Expected outputs for the current cycle from the fetch's offset d since acceptance.
  task automatic model_check(input int k);
    int L, d;
    logic        e_en, e_vld, e_busy;
    logic [9:0]  e_addr;
    logic [127:0] ln;
    L = lat_of(k);
    d = cyc - acc[k];
    if (act[k] && d > L + W + 3) act[k] = 1'b0;
    e_busy = act[k] && (d >= 1);
    e_en   = act[k] && (d >= L + 1) && (d <= L + W);
    e_addr = e_en ? {last_tag[k], 2'(d - L - 1)} : 10'h000;
    e_vld  = act[k] && (d == L + W + 2);
    check_val($sformatf("d%0d busy", k),  busy_w[k], e_busy);
    check_val($sformatf("d%0d rd_en", k), rd_en_w[k], e_en);
    check_val($sformatf("d%0d addr", k),  addr_w[k], e_addr);
    check_val($sformatf("d%0d valid", k), vld_w[k], e_vld);
    check_val($sformatf("d%0d tag", k),   tag_w[k], last_tag[k]);
    if (e_vld) begin
      ln = '0;
      for (int i = 0; i < W; i++) ln[i*32 +: 32] = 32'({last_tag[k], 2'(i)});
      last_line[k] = ln;
      check_val($sformatf("d%0d resp line", k), line_w[k], ln);
    end else if (!act[k] || d <= L + 1 || d >= L + W + 3) begin
      check_val($sformatf("d%0d held line", k), line_w[k], last_line[k]);
    end
  endtask

  task automatic model_accept(input int k);
    if (!act[k] && req_vld) begin
      act[k]      = 1'b1;
      acc[k]      = cyc;
      last_tag[k] = req_tag;
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    req_vld = 1'b0;
    req_tag = 8'h00;
    cyc     = -1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_zero(0);
    check_zero(1);
    rst_n = 1'b1;

    for (cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      model_check(0);
      model_check(1);

      // Asynchronous reset mid-cycle: outputs must clear before any clock edge.
      if (cyc == 43 || (cyc > 100 && $urandom_range(0, 299) == 0)) begin
        rst_n = 1'b0;
        #1;
        check_zero(0);
        check_zero(1);
        model_reset();
        #1;
        rst_n = 1'b1;
      end

      if (cyc < 40) begin
        // Tag 0x12 from cycle 2, switched to 0x20 mid-fetch, dropped later.
        if (cyc == 2)  begin req_vld = 1'b1; req_tag = 8'h12; end
        if (cyc == 5)  req_tag = 8'h20;
        if (cyc == 30) req_vld = 1'b0;
        if (cyc == 40 - 1) begin req_vld = 1'b1; req_tag = 8'h12; end
      end else begin
        if ($urandom_range(0, 7) == 0)  req_tag = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 9) == 0)  req_vld = ~req_vld;
      end

      model_accept(0);
      model_accept(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
